multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: a Moore FSM sequences fetch, decode,
// execute, memory and writeback steps and produces datapath controls.
// Memory states wait on mem_ready. Bad opcodes and bad R-type functs latch a
// sticky illegal flag that only reset clears.
module multicycle_ctrl #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    state_t      state_r;
    state_t      next_s;
    logic        illegal_r;
    logic        illegal_set_s;
    logic        ready_s;
    logic        op_legal_s;
    logic        funct_legal_s;
    logic [2:0]  funct_alu_s;

    logic        mem_req_s;
    logic        iord_s;
    logic        memwrite_s;
    logic        irwrite_s;
    logic        regdst_s;
    logic        memtoreg_s;
    logic        regwrite_s;
    logic        alusrca_s;
    logic        pcwrite_s;
    logic        branch_s;
    logic [1:0]  alusrcb_s;
    logic [1:0]  pcsrc_s;
    logic [1:0]  aluop_s;
    logic [2:0]  alucontrol_s;

    // With waiting disabled the memory is treated as always ready.
    assign ready_s = MEM_WAIT_EN ? mem_ready : 1'b1;

    // State register; reset drops the FSM straight back to FETCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Sticky illegal flag; once set only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_r <= 1'b0;
        end else if (illegal_set_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Opcode legality check used by DECODE.
    always_comb begin
        op_legal_s = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RT, OP_BEQ, OP_ADDI, OP_J: op_legal_s = 1'b1;
            default:                                    op_legal_s = 1'b0;
        endcase
    end

    // R-type funct decode to ALU operation; unknown functs fall back to add.
    always_comb begin
        funct_legal_s = 1'b1;
        funct_alu_s   = 3'b010;
        case (funct)
            6'b100000: funct_alu_s = 3'b010;
            6'b100010: funct_alu_s = 3'b110;
            6'b100100: funct_alu_s = 3'b000;
            6'b100101: funct_alu_s = 3'b001;
            6'b101010: funct_alu_s = 3'b111;
            default: begin
                funct_alu_s   = 3'b010;
                funct_legal_s = 1'b0;
            end
        endcase
    end

    assign illegal_set_s = ((state_r == S_DECODE) && !op_legal_s) ||
                           ((state_r == S_RTEX) && !funct_legal_s);

    // Next-state selection; unused encodings recover to FETCH.
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH:  next_s = ready_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_RT:        next_s = S_RTEX;
                    OP_BEQ:       next_s = S_BEQEX;
                    OP_ADDI:      next_s = S_ADDIEX;
                    OP_J:         next_s = S_JEX;
                    default:      next_s = S_FETCH;
                endcase
            end
            S_MEMADR: next_s = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_s = ready_s ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_s = ready_s ? S_FETCH : S_MEMWR;
            S_RTEX:   next_s = S_RTWB;
            S_ADDIEX: next_s = S_ADDIWB;
            default:  next_s = S_FETCH;
        endcase
    end

    // Moore control decode; write strobes in memory states qualify on ready.
    always_comb begin
        mem_req_s  = 1'b0;
        iord_s     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        regwrite_s = 1'b0;
        alusrca_s  = 1'b0;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        aluop_s    = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_req_s = 1'b1;
                alusrcb_s = 2'b01;
                irwrite_s = ready_s;
                pcwrite_s = ready_s;
            end
            S_DECODE: alusrcb_s = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
            end
            S_MEMWR: begin
                mem_req_s  = 1'b1;
                iord_s     = 1'b1;
                memwrite_s = ready_s;
            end
            S_RTEX: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b10;
            end
            S_RTWB: begin
                regwrite_s = 1'b1;
                regdst_s   = 1'b1;
            end
            S_BEQEX: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b01;
                pcsrc_s   = 2'b01;
                branch_s  = 1'b1;
            end
            S_ADDIWB: regwrite_s = 1'b1;
            S_JEX: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // ALU control from the internal aluop class.
    always_comb begin
        alucontrol_s = 3'b010;
        case (aluop_s)
            2'b00:   alucontrol_s = 3'b010;
            2'b01:   alucontrol_s = 3'b110;
            2'b10:   alucontrol_s = funct_alu_s;
            default: alucontrol_s = 3'b010;
        endcase
    end

    // Outputs are forced low while reset is held so nothing writes mid-reset.
    assign mem_req    = rst & mem_req_s;
    assign iord       = rst & iord_s;
    assign memwrite   = rst & memwrite_s;
    assign irwrite    = rst & irwrite_s;
    assign regdst     = rst & regdst_s;
    assign memtoreg   = rst & memtoreg_s;
    assign regwrite   = rst & regwrite_s;
    assign alusrca    = rst & alusrca_s;
    assign pcen       = rst & (pcwrite_s | (branch_s & zero));
    assign alusrcb    = rst ? alusrcb_s : 2'b00;
    assign pcsrc      = rst ? pcsrc_s : 2'b00;
    assign alucontrol = rst ? alucontrol_s : 3'b000;
    assign illegal    = illegal_r;
    assign state      = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is modelled as an
// ordered list of steps with per-step control expectations.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;
    logic [16:0] ctrl_w;

    int checks = 0;
    int errors = 0;
    logic exp_ill = 1'b0;
    int path_q[$];

    multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .pcen(pcen), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign ctrl_w = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                     alusrca, pcen, alusrcb, pcsrc, alucontrol, illegal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit op_ok(input logic [5:0] o);
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
               (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        if (fn == 6'b100000) return 3'b010;
        if (fn == 6'b100010) return 3'b110;
        if (fn == 6'b100100) return 3'b000;
        if (fn == 6'b100101) return 3'b001;
        if (fn == 6'b101010) return 3'b111;
        return 3'b010;
    endfunction

    function automatic bit funct_ok(input logic [5:0] fn);
        return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
               (fn == 6'b100101) || (fn == 6'b101010);
    endfunction

    // Sequence of steps (debug state codes) an instruction walks through.
    function automatic void build_path(input logic [5:0] o);
        path_q = {0, 1};
        if (o == 6'b100011) path_q = {0, 1, 2, 3, 4};
        if (o == 6'b101011) path_q = {0, 1, 2, 5};
        if (o == 6'b000000) path_q = {0, 1, 6, 7};
        if (o == 6'b000100) path_q = {0, 1, 8};
        if (o == 6'b001000) path_q = {0, 1, 9, 10};
        if (o == 6'b000010) path_q = {0, 1, 11};
    endfunction

    // Expected control word for a step, written from the per-step output table.
    function automatic logic [16:0] model_ctrl(input int st, input logic mr, input logic z,
                                               input logic [5:0] fn, input logic ill);
        logic mreq = 1'b0, io = 1'b0, mw = 1'b0, irw = 1'b0, rd = 1'b0, m2r = 1'b0;
        logic rw = 1'b0, sa = 1'b0, pe = 1'b0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] ac = 3'b010;
        if (st == 0) begin mreq = 1'b1; sb = 2'b01; irw = mr; pe = mr; end
        if (st == 1) sb = 2'b11;
        if (st == 2 || st == 9) begin sa = 1'b1; sb = 2'b10; end
        if (st == 3) begin mreq = 1'b1; io = 1'b1; end
        if (st == 4) begin rw = 1'b1; m2r = 1'b1; end
        if (st == 5) begin mreq = 1'b1; io = 1'b1; mw = mr; end
        if (st == 6) begin sa = 1'b1; ac = funct_alu(fn); end
        if (st == 7) begin rw = 1'b1; rd = 1'b1; end
        if (st == 8) begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; end
        if (st == 10) rw = 1'b1;
        if (st == 11) begin ps = 2'b10; pe = 1'b1; end
        return {mreq, io, mw, irw, rd, m2r, rw, sa, pe, sb, ps, ac, ill};
    endfunction

    // Run one instruction step by step; optional random stalls, a fixed
    // MEMWR stall count, or an asynchronous reset when abort_st is reached.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input logic z,
                             input bit rnd, input int wr_stall, input int abort_st);
        int pos = 0;
        int stalls = 0;
        int consec = 0;
        int st;
        bit adv;
        build_path(o);
        while (pos < path_q.size()) begin
            st = path_q[pos];
            op = o; funct = fn; zero = z;
            if (rnd) mem_ready = (consec < 4) ? ($urandom_range(0, 3) != 0) : 1'b1;
            else if (st == 5 && stalls < wr_stall) begin mem_ready = 1'b0; stalls++; end
            else mem_ready = 1'b1;
            #1;
            chk($sformatf("state op=%b step=%0d", o, pos), state, st);
            chk($sformatf("ctrl op=%b st=%0d mr=%b", o, st, mem_ready), ctrl_w,
                model_ctrl(st, mem_ready, z, fn, exp_ill));
            if (st == abort_st) begin
                rst = 1'b0;
                #1;
                exp_ill = 1'b0;
                chk("abort_state", state, 0);
                chk("abort_memwrite", memwrite, 0);
                chk("abort_mem_req", mem_req, 0);
                chk("abort_enables", {pcen, irwrite, regwrite}, 0);
                chk("abort_illegal", illegal, 0);
                @(posedge clk); #1;
                chk("abort_hold_state", state, 0);
                rst = 1'b1;
                return;
            end
            adv = !((st == 0 || st == 3 || st == 5) && !mem_ready);
            consec = adv ? 0 : consec + 1;
            @(posedge clk); #1;
            if (st == 1 && !op_ok(o)) exp_ill = 1'b1;
            if (st == 6 && !funct_ok(fn)) exp_ill = 1'b1;
            if (adv) pos++;
        end
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] fns [5];
        logic [5:0] o, fn;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b111111, 6'b001111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        rst = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        #3;
        chk("reset_state", state, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_enables", {pcen, irwrite, memwrite, regwrite}, 0);
        chk("reset_illegal", illegal, 0);
        @(posedge clk); #1;
        chk("reset_hold_state", state, 0);
        rst = 1'b1;

        run_instr(6'b100011, 6'b100000, 1'b0, 1'b0, 0, -1);  // lw
        run_instr(6'b101011, 6'b100000, 1'b0, 1'b0, 3, -1);  // sw, MEMWR stall
        run_instr(6'b000000, 6'b101010, 1'b0, 1'b0, 0, -1);  // slt
        run_instr(6'b000100, 6'b100000, 1'b1, 1'b0, 0, -1);  // beq taken
        run_instr(6'b000100, 6'b100000, 1'b0, 1'b0, 0, -1);  // beq not taken
        run_instr(6'b000010, 6'b100000, 1'b0, 1'b0, 0, -1);  // j
        chk("illegal_clear_before", illegal, 0);
        run_instr(6'b111111, 6'b100000, 1'b0, 1'b0, 0, -1);  // bad opcode
        chk("illegal_set", illegal, 1);
        run_instr(6'b001000, 6'b100000, 1'b0, 1'b0, 0, -1);  // addi
        chk("illegal_sticky", illegal, 1);

        for (int i = 0; i < 40; i++) begin
            o  = ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 5) == 0) ? 6'b000011 : fns[$urandom_range(0, 4)];
            run_instr(o, fn, 1'($urandom_range(0, 1)), 1'b1, 0, -1);
        end

        exp_ill = 1'b1;
        run_instr(6'b000000, 6'b000111, 1'b0, 1'b0, 0, -1);  // bad funct
        chk("illegal_funct", illegal, 1);
        run_instr(6'b101011, 6'b100000, 1'b0, 1'b0, 0, 5);   // reset in MEMWR
        chk("illegal_after_reset", illegal, 0);
        run_instr(6'b001000, 6'b100000, 1'b0, 1'b0, 0, -1);  // resume
        chk("illegal_stays_clear", illegal, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
